// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared widths, master indices, arbiter states and default timeout
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_BUS = 2;

  localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_BUS-1:0] BUS_OWNER_MASTER_3 = 2'd3;

  localparam int ARB_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  // Active-low one-cold grant vector for a given owner index.
  function automatic logic [BUS_MASTER_CH-1:0] grant_vec(input logic [BUS_OWNER_BUS-1:0] idx);
    return ~(BUS_MASTER_CH'(1) << idx);
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// rtl/bus_arb_rr_pick.sv - round-robin winner select scanning owner+1..owner+3 then owner
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req_i,
  input  logic [BUS_OWNER_BUS-1:0] owner_i,
  input  logic                     excl_i,
  output logic [BUS_OWNER_BUS-1:0] owner_o,
  output logic                     valid_o
);

  logic [BUS_OWNER_BUS-1:0] cand;

  always_comb begin
    owner_o = owner_i;
    valid_o = 1'b0;
    cand    = owner_i;
    for (int i = 1; i <= BUS_MASTER_CH; i++) begin
      cand = owner_i + BUS_OWNER_BUS'(i);
      if (!valid_o && req_i[cand] && !(excl_i && (cand == owner_i))) begin
        valid_o = 1'b1;
        owner_o = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter; ARB_TIMEOUT_EN enables forced revocation
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       bus_as_,
  input  logic       bus_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       timeout_err
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT out of range");
  end

  arb_state_e               state_q, state_d;
  logic [BUS_OWNER_BUS-1:0] owner_q, owner_d;
  logic [BUS_MASTER_CH-1:0] grnt_q;
  logic                     out_q, out_d;

  logic [BUS_MASTER_CH-1:0] req;
  logic                     owner_req, any_req, can_switch, force_rev, rearb;
  logic [BUS_OWNER_BUS-1:0] pick_owner;
  logic                     pick_valid;

  assign req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req  = req[owner_q];
  assign any_req    = |req;
  // Ready arriving this cycle already finishes the outstanding transfer.
  assign can_switch = !out_q || !bus_rdy_;
  assign out_d      = !bus_rdy_ ? 1'b0 : (!bus_as_ ? 1'b1 : out_q);

  bus_arb_rr_pick u_pick (
    .req_i   (req),
    .owner_i (owner_q),
    .excl_i  (force_rev),
    .owner_o (pick_owner),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rearb   = 1'b0;
    case (state_q)
      ARB_IDLE: rearb = any_req;
      ARB_BUSY, ARB_WAIT: begin
        if (force_rev)       rearb   = 1'b1;
        else if (owner_req)  state_d = ARB_BUSY;
        else if (!can_switch) state_d = ARB_WAIT;
        else if (any_req)    rearb   = 1'b1;
        else                 state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (rearb && pick_valid) begin
      owner_d = pick_owner;
      state_d = req[pick_owner] ? ARB_BUSY : ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= BUS_OWNER_MASTER_0;
      grnt_q  <= grant_vec(BUS_OWNER_MASTER_0);
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grnt_q  <= grant_vec(owner_d);
      out_q   <= out_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q;
  logic        other_req;

  assign other_req = |(req & ~(BUS_MASTER_CH'(1) << owner_q));
  // Count saturates at the limit so a revocation deferred by an open transfer still fires.
  assign force_rev = (state_q == ARB_BUSY) && (cnt_q == 16'(TIMEOUT - 1)) && can_switch && other_req;

  always_comb begin
    cnt_d = cnt_q;
    if ((owner_d != owner_q) || !other_req)                   cnt_d = '0;
    else if (state_q == ARB_BUSY && cnt_q != 16'(TIMEOUT - 1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= force_rev;
    end
  end

  assign timeout_err = err_q;
`else
  assign force_rev   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       bus_as_, bus_rdy_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       timeout_err;
  logic [3:0] grants;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign grants = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  bus_arbiter #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req_     (m0_req_),
    .m1_req_     (m1_req_),
    .m2_req_     (m2_req_),
    .m3_req_     (m3_req_),
    .bus_as_     (bus_as_),
    .bus_rdy_    (bus_rdy_),
    .m0_grnt_    (m0_grnt_),
    .m1_grnt_    (m1_grnt_),
    .m2_grnt_    (m2_grnt_),
    .m3_grnt_    (m3_grnt_),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_own(input string tag, input int k);
    logic [3:0] g;
    g = ~(4'b0001 << k);
    chk({tag, "_grnt"}, grants, g);
    chk({tag, "_owner"}, {2'b00, owner}, 4'(k));
  endtask

  task automatic chk_err(input string tag, input logic exp);
    chk({tag, "_err"}, {3'b000, timeout_err}, {3'b000, exp});
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    order = '{1, 2, 3, 0};

    reset = 1'b0;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;
    bus_as_  = 1'b1;
    bus_rdy_ = 1'b1;
    #12;
    chk_own("rst", 0);
    chk_err("rst", 1'b0);
    @(negedge clk) reset = 1'b1;

    // Parked on master 0 with no requests.
    repeat (10) begin
      step;
      chk_own("park", 0);
    end

    // Single request: grant one cycle later, then parks on master 1.
    m1_req_ = 1'b0;
    step; chk_own("m1_gnt", 1);
    m1_req_ = 1'b1;
    step; chk_own("m1_park", 1);
    step; chk_own("m1_park2", 1);

    // Rotation from owner 0 with all four requesting.
    reset = 1'b0;
    #1 chk_own("rst2", 0);
    @(negedge clk) reset = 1'b1;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b0000;
    step;
    for (int n = 0; n < 4; n++) begin
      chk_own("rr_a", order[n]);
      step; chk_own("rr_b", order[n]);
      step; chk_own("rr_c", order[n]);
      case (order[n])
        0: m0_req_ = 1'b1;
        1: m1_req_ = 1'b1;
        2: m2_req_ = 1'b1;
        default: m3_req_ = 1'b1;
      endcase
      step;
    end
    chk_own("rr_park", 0);

    // Outstanding transfer holds the grant until ready returns.
    m1_req_ = 1'b0;
    m2_req_ = 1'b0;
    step; chk_own("ws_gnt", 1);
    bus_as_ = 1'b0;
    step; chk_own("ws_as", 1);
    bus_as_ = 1'b1;
    m1_req_ = 1'b1;
    step; chk_own("ws_w1", 1);
    step; chk_own("ws_w2", 1);
    step; chk_own("ws_w3", 1);
    bus_rdy_ = 1'b0;
    step; chk_own("ws_done", 2);
    bus_rdy_ = 1'b1;

    // Asynchronous reset while owner 2 waits on an outstanding transfer.
    bus_as_ = 1'b0;
    step; chk_own("w2_as", 2);
    bus_as_ = 1'b1;
    m2_req_ = 1'b1;
    step; chk_own("w2_wait", 2);
    #2 reset = 1'b0;
    #1 chk_own("async_rst", 0);
    chk_err("async_rst", 1'b0);
    @(negedge clk) reset = 1'b1;
    m3_req_ = 1'b0;
    step; chk_own("post_m3", 3);
    m3_req_ = 1'b1;
    m1_req_ = 1'b0;
    step; chk_own("post_free", 1);
    bus_rdy_ = 1'b0;
    step; chk_own("rdy_ignored", 1);
    bus_rdy_ = 1'b1;

    // Master 0 holds the bus while master 3 waits.
    m1_req_ = 1'b1;
    m0_req_ = 1'b0;
    step; chk_own("to_m0", 0);
    m3_req_ = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int n = 1; n <= 7; n++) begin
      step;
      chk_own("to_hold", 0);
      chk_err("to_hold", 1'b0);
    end
    step;
    chk_own("to_revoke", 3);
    chk_err("to_revoke", 1'b1);
    step;
    chk_own("to_after", 3);
    chk_err("to_after", 1'b0);
`else
    repeat (20) begin
      step;
      chk_own("no_to", 0);
      chk_err("no_to", 1'b0);
    end
`endif

    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
